// File: rtl/bitstream_unpacker.sv
`default_nettype none
// =============================================================================
// bitstream_unpacker -- SRAM bitstream fetch + VLC decode to 9-bit coefficients
// Revision 1.0
// =============================================================================
module bitstream_unpacker #(
    parameter logic [17:0] BASE_ADDR  = 18'd76800,
    parameter int          NUM_BLOCKS = 2400
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    output logic        rd_req,
    output logic [17:0] rd_addr,
    input  logic [15:0] rd_data,
    input  logic        rd_valid,
    output logic [8:0]  coeff,
    output logic        coeff_valid,
    input  logic        coeff_ready,
    output logic        coeff_last,
    output logic        done,
    output logic        err
);

    localparam int               BLK_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [BLK_W-1:0] C_LAST_BLK = BLK_W'(NUM_BLOCKS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_DECODE = 3'd2,
        S_RUN    = 3'd3,
        S_EOB    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           r_state;
    logic [31:0]      r_buffer;
    logic [5:0]       r_bit_cnt;
    logic             r_outstanding;
    logic [5:0]       r_coeff_idx;
    logic [BLK_W-1:0] r_block_cnt;
    logic [3:0]       r_run_cnt;

    logic        w_transfer;
    logic        w_slot_free;
    logic        w_final_pending;
    logic        w_can_decode;
    logic        w_is_lit;
    logic        w_is_run;
    logic [3:0]  w_code_len;
    logic [8:0]  w_lit;
    logic [3:0]  w_run_len;
    logic [3:0]  w_consume;
    logic [31:0] w_buf_shifted;
    logic [5:0]  w_cnt_shifted;
    logic        w_accept_word;
    logic [31:0] w_buf_next;
    logic [5:0]  w_cnt_next;
    logic        w_fetch;
    logic        w_emit;
    logic [8:0]  w_emit_val;

    always_comb begin
        w_transfer      = coeff_valid && coeff_ready;
        w_slot_free     = !coeff_valid || coeff_ready;
        // The final coefficient of the last block must not let decoding run ahead.
        w_final_pending = coeff_valid && coeff_last && (r_block_cnt == C_LAST_BLK);
        w_can_decode    = (r_state == S_DECODE) && w_slot_free && !w_final_pending
                          && (r_bit_cnt >= 6'd11);

        w_is_lit   = 1'b0;
        w_is_run   = 1'b0;
        w_code_len = 4'd0;
        w_lit      = 9'd0;
        w_run_len  = 4'd0;
        case (r_buffer[31:30])
            2'b00: begin
                w_is_lit   = 1'b1;
                w_code_len = 4'd5;
                w_lit      = {{6{r_buffer[29]}}, r_buffer[29:27]};
            end
            2'b01: begin
                w_is_lit   = 1'b1;
                w_code_len = 4'd8;
                w_lit      = {{3{r_buffer[29]}}, r_buffer[29:24]};
            end
            2'b10: begin
                w_is_lit   = 1'b1;
                w_code_len = 4'd11;
                w_lit      = r_buffer[29:21];
            end
            default: begin
                if (r_buffer[29]) begin
                    w_code_len = 4'd3;
                end else begin
                    w_is_run   = 1'b1;
                    w_code_len = 4'd6;
                    w_run_len  = (r_buffer[28:26] == 3'd0) ? 4'd8 : {1'b0, r_buffer[28:26]};
                end
            end
        endcase

        w_consume     = w_can_decode ? w_code_len : 4'd0;
        w_buf_shifted = r_buffer << w_consume;
        w_cnt_shifted = r_bit_cnt - {2'b00, w_consume};
        w_accept_word = rd_valid && r_outstanding;
        w_buf_next    = w_buf_shifted;
        w_cnt_next    = w_cnt_shifted;
        // New word lands just below the bits that survive this cycle's shift.
        if (w_accept_word) begin
            w_buf_next = w_buf_shifted | ({rd_data, 16'h0000} >> w_cnt_shifted);
            w_cnt_next = w_cnt_shifted + 6'd16;
        end

        w_fetch = (r_state inside {S_FILL, S_DECODE, S_RUN, S_EOB}) && !r_outstanding
                  && (r_bit_cnt <= 6'd16);

        w_emit = (w_can_decode && w_is_lit)
                 || ((r_state == S_RUN) && w_slot_free)
                 || ((r_state == S_EOB) && w_slot_free);
        w_emit_val = (r_state == S_DECODE) ? w_lit : 9'd0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_buffer      <= 32'd0;
            r_bit_cnt     <= 6'd0;
            r_outstanding <= 1'b0;
            r_coeff_idx   <= 6'd0;
            r_block_cnt   <= '0;
            r_run_cnt     <= 4'd0;
            rd_req        <= 1'b0;
            rd_addr       <= 18'd0;
            coeff         <= 9'd0;
            coeff_valid   <= 1'b0;
            coeff_last    <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            rd_req <= 1'b0;
            if (rd_req) begin
                rd_addr <= rd_addr + 18'd1;
            end
            if (w_accept_word) begin
                r_outstanding <= 1'b0;
            end
            if (w_fetch) begin
                rd_req        <= 1'b1;
                r_outstanding <= 1'b1;
            end
            r_buffer  <= w_buf_next;
            r_bit_cnt <= w_cnt_next;

            if (w_slot_free) begin
                coeff_valid <= 1'b0;
                coeff_last  <= 1'b0;
            end
            if (w_emit) begin
                coeff       <= w_emit_val;
                coeff_valid <= 1'b1;
                coeff_last  <= (r_coeff_idx == 6'd63);
                r_coeff_idx <= r_coeff_idx + 6'd1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state       <= S_FILL;
                        rd_addr       <= BASE_ADDR;
                        r_buffer      <= 32'd0;
                        r_bit_cnt     <= 6'd0;
                        r_outstanding <= 1'b0;
                        r_coeff_idx   <= 6'd0;
                        r_block_cnt   <= '0;
                        err           <= 1'b0;
                        done          <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (r_bit_cnt >= 6'd11) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_can_decode && !w_is_lit) begin
                        if (w_is_run) begin
                            r_run_cnt <= w_run_len;
                            r_state   <= S_RUN;
                        end else begin
                            r_state <= S_EOB;
                        end
                    end
                end
                S_RUN: begin
                    if (w_slot_free) begin
                        r_run_cnt <= r_run_cnt - 4'd1;
                        if (r_run_cnt == 4'd1) begin
                            r_state <= S_DECODE;
                        end else if (r_coeff_idx == 6'd63) begin
                            err     <= 1'b1;
                            r_state <= S_DECODE;
                        end
                    end
                end
                S_EOB: begin
                    if (w_slot_free && (r_coeff_idx == 6'd63)) begin
                        r_state <= S_DECODE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_transfer && coeff_last) begin
                if (r_block_cnt == C_LAST_BLK) begin
                    r_state <= S_DONE;
                    done    <= 1'b1;
                end else begin
                    r_block_cnt <= r_block_cnt + BLK_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bitstream_unpacker.sv
`default_nettype none
// =============================================================================
// tb_bitstream_unpacker -- random/directed code streams vs. a code-level model
// Revision 1.0
// =============================================================================
module tb_bitstream_unpacker;

    localparam logic [17:0] BASE = 18'd76800;
    localparam int          NB   = 2;
    localparam int          NEP  = 9;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        rd_req;
    logic [17:0] rd_addr;
    logic [15:0] rd_data = 16'd0;
    logic        rd_valid = 1'b0;
    logic [8:0]  coeff;
    logic        coeff_valid;
    logic        coeff_ready = 1'b0;
    logic        coeff_last;
    logic        done;
    logic        err;

    bitstream_unpacker #(.BASE_ADDR(BASE), .NUM_BLOCKS(NB)) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .coeff(coeff), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
        .coeff_last(coeff_last), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state: the stream as a bit queue, expected coefficients.
    logic [15:0] mem [256];
    int          nwords = 0;
    bit          bits_q[$];
    int          exp_q[$];
    bit          exp_err;
    int          blk, idx;
    int          ep = 0;
    int          req_cnt = 0;
    int          xfers = 0;
    logic [8:0]  got [64];

    task automatic push_bits(input int len, input int val);
        for (int i = len - 1; i >= 0; i--) bits_q.push_back(val[i]);
    endtask

    task automatic emit_model(input int v);
        exp_q.push_back(v & 511);
        idx++;
        if (idx == 64) begin
            idx = 0;
            blk++;
        end
    endtask

    // kind: 0/1/2 = 3/6/9-bit literal v, 3 = zero run of v (1..8), 4 = end of block
    task automatic add_code(input int kind, input int v);
        case (kind)
            0: push_bits(5, (0 << 3) | (v & 7));
            1: push_bits(8, (1 << 6) | (v & 63));
            2: push_bits(11, (2 << 9) | (v & 511));
            3: push_bits(6, (6 << 3) | (v & 7));
            default: push_bits(3, 7);
        endcase
        if (blk >= NB) return;
        case (kind)
            0, 1, 2: emit_model(v);
            3: for (int k = 0; k < v; k++) begin
                emit_model(0);
                if (idx == 0) begin
                    if (k < v - 1) exp_err = 1'b1;
                    break;
                end
            end
            default: do emit_model(0); while (idx != 0);
        endcase
    endtask

    task automatic build_episode(input int e);
        int r;
        bits_q.delete();
        exp_q.delete();
        blk = 0;
        idx = 0;
        exp_err = 1'b0;
        case (e)
            0: begin add_code(0, 3); add_code(1, -1); end
            1: begin add_code(2, -256); add_code(0, -4); end
            2: begin add_code(3, 8); add_code(0, 1); end
            3: begin
                for (int i = 0; i < 60; i++) add_code(0, int'($urandom_range(0, 7)) - 4);
                add_code(3, 8);
            end
            4: ;
            default: while (blk < NB) begin
                r = int'($urandom_range(0, 99));
                if (r < 30)      add_code(0, int'($urandom_range(0, 7)) - 4);
                else if (r < 55) add_code(1, int'($urandom_range(0, 63)) - 32);
                else if (r < 75) add_code(2, int'($urandom_range(0, 511)) - 256);
                else if (r < 96) add_code(3, int'($urandom_range(1, 8)));
                else             add_code(4, 0);
            end
        endcase
        while (blk < NB) add_code(4, 0);
        for (int i = 0; i < 48; i++) bits_q.push_back(1'($urandom_range(0, 1)));
        while (bits_q.size() % 16 != 0) bits_q.push_back(1'($urandom_range(0, 1)));
        nwords = bits_q.size() / 16;
        for (int w = 0; w < nwords; w++)
            for (int b = 0; b < 16; b++) mem[w][15-b] = bits_q[16*w + b];
    endtask

    // SRAM responder: random latency 1..4, addresses must run sequentially from BASE.
    int          sram_a, sram_lat;
    logic [15:0] sram_d;
    initial begin
        forever begin
            @(negedge clock);
            if (rd_req === 1'b1) begin
                check_val("rd_addr", 32'(rd_addr), 32'(BASE) + 32'(req_cnt));
                req_cnt++;
                sram_a = int'(rd_addr) - int'(BASE);
                sram_d = (sram_a >= 0 && sram_a < nwords) ? mem[sram_a] : 16'($urandom);
                sram_lat = int'($urandom_range(1, 4));
                repeat (sram_lat) @(posedge clock);
                #1 rd_valid = 1'b1;
                rd_data = sram_d;
                @(posedge clock);
                #1 rd_valid = 1'b0;
                rd_data = 16'($urandom);
            end
        end
    end

    // Downstream: random ready, full rate in episode 4, a 5-cycle stall in episode 5.
    int stall_cnt = 0;
    bit stall_done = 1'b0;
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (ep == 5 && xfers >= 20 && !stall_done) begin
                stall_cnt = 5;
                stall_done = 1'b1;
            end
            if (stall_cnt > 0) begin
                coeff_ready = 1'b0;
                stall_cnt--;
            end else begin
                coeff_ready = ($urandom_range(0, 99) < ((ep == 4) ? 100 : 70));
            end
        end
    end

    bit         mon_en = 1'b0;
    bit         prev_stall = 1'b0;
    logic [8:0] prev_coeff;
    logic       prev_last;
    int         exp_v;
    always @(negedge clock) begin
        if (mon_en) begin
            if (prev_stall) begin
                check_val("hold_valid", 32'(coeff_valid), 32'd1);
                check_val("hold_coeff", 32'(coeff), 32'(prev_coeff));
                check_val("hold_last", 32'(coeff_last), 32'(prev_last));
            end
            if (coeff_valid && coeff_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_coeff", 32'(coeff_valid), 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check_val("coeff", 32'(coeff), 32'(exp_v));
                    check_val("coeff_last", 32'(coeff_last), 32'((xfers % 64) == 63));
                    if (xfers < 64) got[xfers] = coeff;
                    xfers++;
                end
            end
            prev_stall = coeff_valid && !coeff_ready;
            prev_coeff = coeff;
            prev_last  = coeff_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_rd_req"}, 32'(rd_req), 32'd0);
        check_val({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check_val({tag, "_coeff"}, 32'(coeff), 32'd0);
        check_val({tag, "_coeff_valid"}, 32'(coeff_valid), 32'd0);
        check_val({tag, "_coeff_last"}, 32'(coeff_last), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic run_episode(input int e);
        int cyc;
        ep = e;
        build_episode(e);
        req_cnt = 0;
        xfers = 0;
        mon_en = 1'b1;
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check_val("done", 32'(done), 32'd1);
        check_val("remaining", 32'(exp_q.size()), 32'd0);
        check_val("xfer_count", 32'(xfers), 32'(64 * NB));
        check_val("err", 32'(err), 32'(exp_err));
        case (e)
            0: begin
                check_val("t1_c0", 32'(got[0]), 32'h003);
                check_val("t1_c1", 32'(got[1]), 32'h1FF);
                check_val("t1_c63", 32'(got[63]), 32'h000);
            end
            1: begin
                check_val("t2_c0", 32'(got[0]), 32'h100);
                check_val("t2_c1", 32'(got[1]), 32'h1FC);
            end
            2: begin
                check_val("t3_c7", 32'(got[7]), 32'h000);
                check_val("t3_c8", 32'(got[8]), 32'h001);
            end
            3: check_val("t5_err", 32'(err), 32'd1);
            default: ;
        endcase
        repeat (10) begin
            @(posedge clock);
            #1;
            check_val("rd_req_in_done", 32'(rd_req), 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        resetn = 1'b1;
        @(posedge clock);
        #1;
        for (int e = 0; e < NEP; e++) run_episode(e);

        // Reset in the middle of a block.
        ep = NEP;
        build_episode(NEP);
        req_cnt = 0;
        xfers = 0;
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (120) @(posedge clock);
        #1 mon_en = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        repeat (4) @(posedge clock);
        #1 resetn = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        check_outputs_zero("after_rst");
        run_episode(NEP + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
